fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, framebuffer word address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width (8 pixels x 4 bits).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 frame_end  input  1  one-cycle pulse from the timing generator.
REQ-006 vid_req, vid_addr  input  1, ADDR_W  video read request and address.
REQ-007 vid_rvalid, vid_rdata  output  1, DATA_W  video read return.
REQ-008 eng_req, eng_we, eng_addr, eng_wdata  input  1, 1, ADDR_W, DATA_W  update-engine access.
REQ-009 eng_gnt  output  1  engine access accepted this cycle.
REQ-010 eng_rvalid, eng_rdata  output  1, DATA_W  engine read return.
REQ-011 eng_done  input  1  pulse; engine finished the current generation.
REQ-012 eng_start  output  1  pulse; engine may begin a generation.
REQ-013 mem_bank, mem_addr, mem_we, mem_wdata  output  1, ADDR_W, 1, DATA_W  single-port memory drive.
REQ-014 mem_rdata  input  DATA_W  memory read data, valid one cycle after address.
REQ-015 disp_bank  output  1  bank currently displayed.
REQ-016 stall_cnt  output  16  engine stall counter (see Configuration).

Function
REQ-017 Memory port SHALL be driven combinationally from the granted requester in the same cycle.
REQ-018 Video SHALL have absolute priority: vid_req always granted; mem_bank=disp_bank, mem_we=0.
REQ-019 eng_gnt SHALL be eng_req AND NOT vid_req AND state==RUN.
REQ-020 Granted engine read SHALL use mem_bank=disp_bank; granted engine write SHALL use mem_bank=~disp_bank, mem_we=1.
REQ-021 Engine SHALL hold eng_req/eng_we/eng_addr/eng_wdata stable until eng_gnt; arbiter SHALL not queue.
REQ-022 vid_rvalid SHALL assert exactly one cycle after a video grant with vid_rdata=mem_rdata; likewise eng_rvalid for granted engine reads only.
REQ-023 With no grant, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold last value.
REQ-024 State machine IDLE, RUN, DONE.
REQ-025 IDLE: on frame_end go RUN, pulse eng_start next cycle.
REQ-026 RUN: on eng_done go DONE; eng_done and frame_end same cycle SHALL toggle disp_bank, pulse eng_start, stay RUN.
REQ-027 DONE: on frame_end toggle disp_bank, go RUN, pulse eng_start.
REQ-028 frame_end in RUN without eng_done SHALL be ignored (no swap; frame repeats).
REQ-029 eng_done outside RUN SHALL be ignored.
REQ-030 disp_bank SHALL change only at frame_end, never mid-frame.

Reset
REQ-031 Reset SHALL set state IDLE, disp_bank 0, all valid/gnt/start/we outputs 0, mem_addr/mem_wdata/data outputs 0, stall_cnt 0.
REQ-032 Reset mid-access SHALL cancel any pending rvalid; no write SHALL occur in the reset cycle.

Configuration
REQ-033 With FBARB_STALL_CNT_EN defined, stall_cnt SHALL increment (saturating at 0xFFFF) each cycle eng_req=1, state==RUN and eng_gnt=0.
REQ-034 Without FBARB_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-035 Reset, then frame_end -> eng_start pulse 1 cycle later, state RUN, disp_bank=0.
REQ-036 vid_req and eng_req (read, addr 0x005) same cycle -> vid granted, eng_gnt=0; next cycle vid_req=0 -> eng_gnt=1, mem_bank=0, eng_rvalid one cycle later.
REQ-037 Engine write addr 0x1FF data 0xDEADBEEF -> mem_we=1, mem_bank=1, mem_addr=0x1FF.
REQ-038 eng_done then frame_end -> disp_bank 0->1 at frame_end, eng_start pulse; frame_end without prior eng_done -> no toggle.
REQ-039 eng_done and frame_end same cycle -> immediate toggle, state RUN.
REQ-040 With FBARB_STALL_CNT_EN, eng_req held under 10 consecutive vid_req cycles -> stall_cnt=10; without macro -> 0.

Source files
------------

// File: rtl/fb_arbiter.sv
// Framebuffer port arbiter: video reads have absolute priority over the update engine.
// Optional engine stall counter enabled by defining FBARB_STALL_CNT_EN.
module fb_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_end,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  input  logic              eng_done,
  output logic              eng_start,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_bank,
  output logic [15:0]       stall_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic              disp_bank_reg, disp_bank_next;
  logic              eng_start_reg, eng_start_next;
  logic              vid_rvalid_reg, eng_rvalid_reg;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] wdata_hold_reg;
  logic              vid_gnt, eng_gnt_w;

  // Grants are masked during reset so nothing reaches memory in the reset cycle.
  assign vid_gnt   = vid_req & ~reset;
  assign eng_gnt_w = eng_req & ~vid_req & (state_reg == ST_RUN) & ~reset;

  always_comb begin
    mem_bank  = disp_bank_reg;
    mem_addr  = addr_hold_reg;
    mem_we    = 1'b0;
    mem_wdata = wdata_hold_reg;
    if (vid_gnt) begin
      mem_addr = vid_addr;
    end else if (eng_gnt_w) begin
      mem_addr  = eng_addr;
      mem_wdata = eng_wdata;
      mem_we    = eng_we;
      mem_bank  = eng_we ? ~disp_bank_reg : disp_bank_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    disp_bank_next = disp_bank_reg;
    eng_start_next = 1'b0;
    case (state_reg)
      ST_IDLE: if (frame_end) begin
        state_next     = ST_RUN;
        eng_start_next = 1'b1;
      end
      ST_RUN: if (eng_done && frame_end) begin
        disp_bank_next = ~disp_bank_reg;
        eng_start_next = 1'b1;
      end else if (eng_done) begin
        state_next = ST_DONE;
      end
      ST_DONE: if (frame_end) begin
        disp_bank_next = ~disp_bank_reg;
        state_next     = ST_RUN;
        eng_start_next = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      disp_bank_reg  <= 1'b0;
      eng_start_reg  <= 1'b0;
      vid_rvalid_reg <= 1'b0;
      eng_rvalid_reg <= 1'b0;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
    end else begin
      state_reg      <= state_next;
      disp_bank_reg  <= disp_bank_next;
      eng_start_reg  <= eng_start_next;
      vid_rvalid_reg <= vid_gnt;
      eng_rvalid_reg <= eng_gnt_w & ~eng_we;
      addr_hold_reg  <= mem_addr;
      wdata_hold_reg <= mem_wdata;
    end
  end

  assign eng_gnt    = eng_gnt_w;
  assign eng_start  = eng_start_reg;
  assign disp_bank  = disp_bank_reg;
  assign vid_rvalid = vid_rvalid_reg;
  assign eng_rvalid = eng_rvalid_reg;
  // Read data is only meaningful alongside its valid; otherwise forced to zero.
  assign vid_rdata  = vid_rvalid_reg ? mem_rdata : '0;
  assign eng_rdata  = eng_rvalid_reg ? mem_rdata : '0;

`ifdef FBARB_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (eng_req && (state_reg == ST_RUN) && !eng_gnt_w && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: read returns checked by a queue-based scoreboard,
// control outputs checked inline at the falling edge.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset, frame_end, vid_req, eng_req, eng_we, eng_done;
  logic [8:0]  vid_addr, eng_addr;
  logic [31:0] eng_wdata;
  logic        vid_rvalid, eng_gnt, eng_rvalid, eng_start, mem_bank, mem_we, disp_bank;
  logic [31:0] vid_rdata, eng_rdata, mem_wdata, mem_rdata;
  logic [8:0]  mem_addr;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] vid_q[$];
  logic [31:0] eng_q[$];
  logic [31:0] mem [0:1][0:511];

  always #5 clk = ~clk;

  fb_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .frame_end(frame_end),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
    .eng_done(eng_done), .eng_start(eng_start),
    .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .disp_bank(disp_bank), .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] pat(input logic b, input logic [8:0] a);
    return 32'hC0DE0000 | ({31'd0, b} << 12) | {23'd0, a};
  endfunction

  // Two-bank single-port memory, one cycle read latency.
  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++)
        mem[b][a] = pat(b[0], a[8:0]);
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_bank][mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_bank][mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever a read return appears.
  always @(negedge clk) begin
    if (vid_rvalid === 1'b1) begin
      if (vid_q.size() == 0) chk("vid_rvalid_unexpected", 32'd1, 32'd0);
      else chk("vid_rdata", vid_rdata, vid_q.pop_front());
    end
    if (eng_rvalid === 1'b1) begin
      if (eng_q.size() == 0) chk("eng_rvalid_unexpected", 32'd1, 32'd0);
      else chk("eng_rdata", eng_rdata, eng_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    frame_end = 0; vid_req = 0; eng_req = 0; eng_we = 0; eng_done = 0;
    vid_addr = '0; eng_addr = '0; eng_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    step(); step();
    reset = 0;
  endtask

  task automatic pulse_frame_end();
    frame_end = 1; step(); frame_end = 0;
  endtask

  initial begin
    do_reset();
    settle();
    chk("rst_disp_bank", {31'd0, disp_bank}, 32'd0);
    chk("rst_eng_start", {31'd0, eng_start}, 32'd0);
    chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // IDLE -> RUN with engine start one cycle after frame_end
    step(); pulse_frame_end(); settle();
    chk("start_pulse", {31'd0, eng_start}, 32'd1);
    chk("start_disp_bank", {31'd0, disp_bank}, 32'd0);
    step(); settle();
    chk("start_pulse_end", {31'd0, eng_start}, 32'd0);

    // Video beats engine in the same cycle
    step();
    vid_req = 1; vid_addr = 9'h010; eng_req = 1; eng_we = 0; eng_addr = 9'h005;
    vid_q.push_back(pat(1'b0, 9'h010));
    settle();
    chk("vid_prio_eng_gnt", {31'd0, eng_gnt}, 32'd0);
    chk("vid_prio_mem_addr", {23'd0, mem_addr}, 32'h010);
    chk("vid_prio_mem_we", {31'd0, mem_we}, 32'd0);
    step();
    vid_req = 0;
    eng_q.push_back(pat(1'b0, 9'h005));
    settle();
    chk("eng_rd_gnt", {31'd0, eng_gnt}, 32'd1);
    chk("eng_rd_bank", {31'd0, mem_bank}, 32'd0);
    chk("eng_rd_addr", {23'd0, mem_addr}, 32'h005);
    step();
    eng_req = 0; settle();
    chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
    chk("idle_addr_hold", {23'd0, mem_addr}, 32'h005);

    // Engine write goes to the back bank
    step();
    eng_req = 1; eng_we = 1; eng_addr = 9'h1FF; eng_wdata = 32'hDEADBEEF;
    settle();
    chk("eng_wr_gnt", {31'd0, eng_gnt}, 32'd1);
    chk("eng_wr_we", {31'd0, mem_we}, 32'd1);
    chk("eng_wr_bank", {31'd0, mem_bank}, 32'd1);
    chk("eng_wr_addr", {23'd0, mem_addr}, 32'h1FF);
    chk("eng_wr_data", mem_wdata, 32'hDEADBEEF);
    step();
    eng_req = 0; eng_we = 0;

    // frame_end without eng_done repeats the frame
    pulse_frame_end(); settle();
    chk("noswap_disp_bank", {31'd0, disp_bank}, 32'd0);
    chk("noswap_eng_start", {31'd0, eng_start}, 32'd0);

    // eng_done, then frame_end swaps banks
    step(); eng_done = 1; step(); eng_done = 0; settle();
    chk("done_wait_bank", {31'd0, disp_bank}, 32'd0);
    step(); step(); pulse_frame_end(); settle();
    chk("swap_disp_bank", {31'd0, disp_bank}, 32'd1);
    chk("swap_eng_start", {31'd0, eng_start}, 32'd1);

    // Written word is now on the displayed bank
    step();
    vid_req = 1; vid_addr = 9'h1FF;
    vid_q.push_back(32'hDEADBEEF);
    step();
    vid_req = 0; eng_req = 1; eng_we = 0; eng_addr = 9'h1FF;
    eng_q.push_back(32'hDEADBEEF);
    settle();
    chk("swapped_rd_bank", {31'd0, mem_bank}, 32'd1);
    step(); eng_req = 0;

    // eng_done and frame_end together: immediate swap, stay in RUN
    eng_done = 1; frame_end = 1; step(); eng_done = 0; frame_end = 0; settle();
    chk("same_cyc_disp_bank", {31'd0, disp_bank}, 32'd0);
    chk("same_cyc_eng_start", {31'd0, eng_start}, 32'd1);
    step();
    eng_req = 1; eng_we = 0; eng_addr = 9'h005;
    eng_q.push_back(pat(1'b0, 9'h005));
    settle();
    chk("same_cyc_run_gnt", {31'd0, eng_gnt}, 32'd1);
    step(); eng_req = 0;

    // Reset mid-access: no write, no read return
    reset = 1; vid_req = 1; vid_addr = 9'h020; eng_req = 1; eng_we = 1; eng_addr = 9'h030;
    settle();
    chk("rst_cyc_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_cyc_eng_gnt", {31'd0, eng_gnt}, 32'd0);
    step();
    idle_inputs(); step();
    reset = 0; settle();
    chk("rst_cyc_vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
    chk("rst_cyc_disp_bank", {31'd0, disp_bank}, 32'd0);

    // Engine stalled behind 10 video cycles
    step(); pulse_frame_end(); step();
    vid_req = 1; vid_addr = 9'h000; eng_req = 1; eng_we = 0; eng_addr = 9'h003;
    for (int i = 0; i < 10; i++) begin
      vid_q.push_back(pat(1'b0, 9'h000));
      step();
    end
    vid_req = 0;
    eng_q.push_back(pat(1'b0, 9'h003));
    settle();
    chk("stall_gnt_after", {31'd0, eng_gnt}, 32'd1);
`ifdef FBARB_STALL_CNT_EN
    chk("stall_cnt", {16'd0, stall_cnt}, 32'd10);
`else
    chk("stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    step(); eng_req = 0;

    // Bounded drain of outstanding read returns
    for (int i = 0; i < 5 && (vid_q.size() != 0 || eng_q.size() != 0); i++) step();
    chk("vid_q_drained", vid_q.size(), 32'd0);
    chk("eng_q_drained", eng_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
